// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and defaults for the UART receive FIFO.
// Default depth, byte type and the capture-handshake state encoding.
package uart_rx_fifo_pkg;

    localparam int UART_RX_FIFO_DEPTH_DEFAULT = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } cap_state_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x 8 register file: synchronous write port, asynchronous read port.
// Contents are deliberately left unreset; occupancy is tracked by the owner.
module uart_rx_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter  int DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    byte_t mem_r [DEPTH];

    // Storage write on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: drains bytes via the has_byte/clr_hb handshake and
// exposes a show-ahead CPU read port. UART_RX_FIFO_THRESH_EN adds a thresh irq.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  uart_dout,
    input  logic        uart_has_byte,
    output logic        uart_clr_hb,
    input  logic        rd_en,
    output logic [7:0]  dout,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count,
    output logic        overrun,
    input  logic        ovr_clr,
`ifdef UART_RX_FIFO_THRESH_EN
    input  logic [AW:0] thresh,
`endif
    output logic        irq
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ZERO_C  = (AW+1)'(0);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PINC_C  = AW'(1);

    cap_state_t    state_r, state_s;
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r;
    logic          clr_hb_r, clr_hb_s;
    logic          overrun_r, irq_r, irq_s;
    logic          capture_s, push_s, pop_s, drop_s;
    byte_t         rdata_s;

    // Capture FSM next state: one acknowledge cycle per byte seen in IDLE.
    always_comb begin
        state_s   = state_r;
        clr_hb_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (uart_has_byte) begin
                    state_s   = ACK;
                    clr_hb_s  = 1'b1;
                    capture_s = 1'b1;
                end else begin
                    state_s   = IDLE;
                end
            end
            ACK:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // A full FIFO still accepts when the CPU frees a slot in the same cycle.
    assign pop_s  = rd_en && (count_r != ZERO_C);
    assign push_s = capture_s && ((count_r < DEPTH_C) || rd_en);
    assign drop_s = capture_s && !push_s;

    // Interrupt condition, sampled into irq_r so irq lags count by one cycle.
    always_comb begin
`ifdef UART_RX_FIFO_THRESH_EN
        irq_s = (count_r >= thresh) && (thresh != ZERO_C);
`else
        irq_s = (count_r != ZERO_C);
`endif
    end

    // Handshake, pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            clr_hb_r  <= 1'b0;
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= ZERO_C;
            overrun_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            clr_hb_r <= clr_hb_s;
            irq_r    <= irq_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PINC_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PINC_C;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (uart_dout),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Head byte is combinational so the CPU read mux sees it without delay.
    assign empty       = (count_r == ZERO_C);
    assign full        = (count_r == DEPTH_C);
    assign dout        = empty ? 8'h00 : rdata_s;
    assign count       = count_r;
    assign overrun     = overrun_r;
    assign irq         = irq_r;
    assign uart_clr_hb = clr_hb_r;

endmodule
